// File: rtl/mbist_seq_ctrl_if.sv
// MBIST engine control/status bundle shared between the sequencer and the engine.
interface mbist_seq_ctrl_if #(
  parameter int BIST_NO_SRAM = 4
);
  logic                    bist_en;
  logic                    bist_run;
  logic                    bist_shift;
  logic                    bist_load;
  logic                    bist_sdi;
  logic                    bist_done;
  logic [BIST_NO_SRAM-1:0] bist_error;
  logic                    bist_sdo;

  modport master (
    output bist_en, bist_run, bist_shift, bist_load, bist_sdi,
    input  bist_done, bist_error, bist_sdo
  );

  modport slave (
    input  bist_en, bist_run, bist_shift, bist_load, bist_sdi,
    output bist_done, bist_error, bist_sdo
  );
endinterface

// File: rtl/mbist_seq_ctrl.sv
// MBIST sequencer: runs test-and-readout or repair-load sequences on the engine
// and keeps sticky status. All engine controls come straight from flops.
module mbist_seq_ctrl #(
  parameter int BIST_NO_SRAM = 4,
  parameter int BIST_ADDR_WD = 9,
  parameter int SHIFT_LEN    = BIST_NO_SRAM * BIST_ADDR_WD,
  parameter int SETUP_CYC    = 4,
  parameter int TMO_WD       = 20
) (
  input  logic                    wb_clk_i,
  input  logic                    wb_rst_i,
  input  logic                    cfg_start,
  input  logic                    cfg_load,
  input  logic                    cfg_abort,
  input  logic [SHIFT_LEN-1:0]    cfg_repair_addr,
  mbist_seq_ctrl_if.master        bist,
  output logic                    sts_busy,
  output logic                    sts_done,
  output logic                    sts_timeout,
  output logic [BIST_NO_SRAM-1:0] sts_err_mask,
  output logic [SHIFT_LEN-1:0]    sts_err_addr
);

  localparam int SCW = $clog2(SHIFT_LEN + 1);
  localparam int UCW = $clog2(SETUP_CYC + 1);
  localparam logic [SCW-1:0] SHIFT_LAST = SCW'(SHIFT_LEN - 1);
  localparam logic [UCW-1:0] SETUP_LAST = UCW'(SETUP_CYC - 1);

  typedef enum logic [2:0] {
    IDLE, SETUP, RUN, RDSHIFT, LDSHIFT, LDPULSE, DONE
  } state_t;

  state_t               state;
  state_t               state_next;
  logic [UCW-1:0]       setup_cnt;
  logic [SCW-1:0]       shift_cnt;
  logic [TMO_WD-1:0]    tmo_cnt;
  logic [SHIFT_LEN-1:0] load_sreg;
  logic                 en_next;
  logic                 run_next;
  logic                 shift_next;
  logic                 load_next;
  logic                 take_start;
  logic                 take_load;
  logic                 run_done;
  logic                 run_timeout;

  // Accepted requests and RUN exits; abort masks all of them, start beats load.
  always_comb begin
    take_start  = (state == IDLE) && cfg_start && !cfg_abort;
    take_load   = (state == IDLE) && cfg_load && !cfg_start && !cfg_abort;
    run_done    = (state == RUN) && bist.bist_done && !cfg_abort;
    run_timeout = (state == RUN) && !bist.bist_done && (&tmo_cnt) && !cfg_abort;
  end

  // Next-state decode plus the engine controls that go with the next state.
  always_comb begin
    state_next = state;
    if (cfg_abort) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (cfg_start)     state_next = SETUP;
          else if (cfg_load) state_next = LDSHIFT;
        end
        SETUP:   if (setup_cnt == SETUP_LAST) state_next = RUN;
        RUN: begin
          if (bist.bist_done)  state_next = RDSHIFT;
          else if (&tmo_cnt)   state_next = IDLE;
        end
        RDSHIFT: if (shift_cnt == SHIFT_LAST) state_next = DONE;
        LDSHIFT: if (shift_cnt == SHIFT_LAST) state_next = LDPULSE;
        LDPULSE: state_next = DONE;
        DONE:    state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
    en_next    = state_next inside {SETUP, RUN, RDSHIFT, LDSHIFT, LDPULSE};
    run_next   = (state_next == RUN);
    shift_next = state_next inside {RDSHIFT, LDSHIFT};
    load_next  = (state_next == LDPULSE);
  end

  // State register.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) state <= IDLE;
    else          state <= state_next;
  end

  // Registered engine controls, counters, load shifter and sticky status.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      bist.bist_en    <= 1'b0;
      bist.bist_run   <= 1'b0;
      bist.bist_shift <= 1'b0;
      bist.bist_load  <= 1'b0;
      bist.bist_sdi   <= 1'b0;
      sts_busy        <= 1'b0;
      sts_done        <= 1'b0;
      sts_timeout     <= 1'b0;
      sts_err_mask    <= '0;
      sts_err_addr    <= '0;
      setup_cnt       <= '0;
      shift_cnt       <= '0;
      tmo_cnt         <= '0;
      load_sreg       <= '0;
    end else begin
      bist.bist_en    <= en_next;
      bist.bist_run   <= run_next;
      bist.bist_shift <= shift_next;
      bist.bist_load  <= load_next;
      sts_busy        <= (state_next != IDLE);

      setup_cnt <= (state == SETUP) ? setup_cnt + 1'b1 : '0;
      tmo_cnt   <= (state == RUN) ? tmo_cnt + 1'b1 : '0;
      shift_cnt <= (state inside {RDSHIFT, LDSHIFT}) ? shift_cnt + 1'b1 : '0;

      if (state == RDSHIFT)
        sts_err_addr <= {sts_err_addr[SHIFT_LEN-2:0], bist.bist_sdo};

      if (run_done)
        sts_err_mask <= bist.bist_error;

      if (take_load) begin
        bist.bist_sdi <= cfg_repair_addr[SHIFT_LEN-1];
        load_sreg     <= {cfg_repair_addr[SHIFT_LEN-2:0], 1'b0};
      end else if (state == LDSHIFT && state_next == LDSHIFT) begin
        bist.bist_sdi <= load_sreg[SHIFT_LEN-1];
        load_sreg     <= {load_sreg[SHIFT_LEN-2:0], 1'b0};
      end else begin
        bist.bist_sdi <= 1'b0;
      end

      if (take_start)       sts_timeout <= 1'b0;
      else if (run_timeout) sts_timeout <= 1'b1;

      if (take_start || take_load)            sts_done <= 1'b0;
      else if (state == DONE && !cfg_abort)   sts_done <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mbist_seq_ctrl.sv
// Directed bench for mbist_seq_ctrl: a per-cycle vector table plus hand-written
// multi-cycle sequences (readout, load, timeout, abort, reset).
module tb_mbist_seq_ctrl;
  localparam int NS = 4;
  localparam int SL = 36;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cfg_start = 1'b0;
  logic          cfg_load = 1'b0;
  logic          cfg_abort = 1'b0;
  logic [SL-1:0] cfg_repair_addr = '0;

  logic          busy, done, tmo;
  logic [NS-1:0] mask;
  logic [SL-1:0] addr;
  logic          t_busy, t_done, t_tmo;
  logic [NS-1:0] t_mask;
  logic [SL-1:0] t_addr;

  int checks = 0;
  int fails = 0;

  mbist_seq_ctrl_if #(.BIST_NO_SRAM(NS)) bus ();
  mbist_seq_ctrl_if #(.BIST_NO_SRAM(NS)) tbus ();

  mbist_seq_ctrl dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .cfg_start(cfg_start), .cfg_load(cfg_load),
    .cfg_abort(cfg_abort), .cfg_repair_addr(cfg_repair_addr), .bist(bus),
    .sts_busy(busy), .sts_done(done), .sts_timeout(tmo),
    .sts_err_mask(mask), .sts_err_addr(addr)
  );

  mbist_seq_ctrl #(.TMO_WD(4)) dut_tmo (
    .wb_clk_i(clk), .wb_rst_i(rst), .cfg_start(cfg_start), .cfg_load(cfg_load),
    .cfg_abort(cfg_abort), .cfg_repair_addr(cfg_repair_addr), .bist(tbus),
    .sts_busy(t_busy), .sts_done(t_done), .sts_timeout(t_tmo),
    .sts_err_mask(t_mask), .sts_err_addr(t_addr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          start;
    logic          load;
    logic          abort;
    logic          bdone;
    logic [NS-1:0] err;
    logic [9:0]    expect_out;  // {en, run, shift, load, sdi, busy, err_mask}
  } vec_t;

  vec_t vecs[12];

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic apply_stimulus(input vec_t v);
    cfg_start       = v.start;
    cfg_load        = v.load;
    cfg_abort       = v.abort;
    bus.bist_done   = v.bdone;
    bus.bist_error  = v.err;
  endtask

  function automatic bit excl_bad();
    return $countones({bus.bist_run, bus.bist_shift, bus.bist_load}) > 1;
  endfunction

  function automatic logic [9:0] main_out();
    return {bus.bist_en, bus.bist_run, bus.bist_shift, bus.bist_load, bus.bist_sdi, busy, mask};
  endfunction

  // Start a test, hold bist_done low for 100 RUN cycles, then read out the
  // chain from stream; optionally abort or reset at shift index stop_at.
  task automatic run_test(input logic [NS-1:0] err, input logic [SL-1:0] stream,
                          input int stop_at, input bit use_reset,
                          output int setup_n, output int shift_n, output int bad_n);
    int guard;
    int k;
    setup_n = 0; shift_n = 0; bad_n = 0; k = 0;
    bus.bist_error = err; bus.bist_done = 1'b0; bus.bist_sdo = 1'b0;
    cfg_start = 1'b1; tick(); cfg_start = 1'b0;
    guard = 0;
    while (!bus.bist_run && guard < 20) begin
      if (bus.bist_en) setup_n++;
      guard++; tick();
    end
    check_output("run_entry", bus.bist_run, 1);
    for (int i = 0; i < 100; i++) begin
      if (excl_bad() || !bus.bist_en) bad_n++;
      if (i == 99) bus.bist_done = 1'b1;
      tick();
    end
    bus.bist_done = 1'b0;
    guard = 0;
    while (bus.bist_shift && guard < SL + 5) begin
      if (excl_bad() || !bus.bist_en || bus.bist_sdi) bad_n++;
      bus.bist_sdo = (k < SL) ? stream[SL-1-k] : 1'b0;
      shift_n++;
      if (k == stop_at) begin
        if (use_reset) rst = 1'b1;
        else           cfg_abort = 1'b1;
        tick();
        rst = 1'b0; cfg_abort = 1'b0; bus.bist_sdo = 1'b0;
        return;
      end
      k++; guard++; tick();
    end
    bus.bist_sdo = 1'b0;
    guard = 0;
    while (busy && guard < 10) begin
      if (bus.bist_en) bad_n++;
      guard++; tick();
    end
    check_output("idle_return", busy, 0);
  endtask

  // Watchdog so a stuck design still ends the run.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no finish, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Main test sequence.
  initial begin
    int sn, hn, bn, n, guard;
    logic [SL-1:0] cap;
    logic [SL-1:0] exp_addr;

    bus.bist_done = 1'b0; bus.bist_error = '0; bus.bist_sdo = 1'b0;
    tbus.bist_done = 1'b0; tbus.bist_error = '0; tbus.bist_sdo = 1'b0;

    vecs[0]  = '{1'b1, 1'b1, 1'b0, 1'b0, 4'b0000, 10'b1000010000};
    vecs[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 10'b1000010000};
    vecs[2]  = '{1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 10'b1000010000};
    vecs[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 10'b1000010000};
    vecs[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 10'b1100010000};
    vecs[5]  = '{1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 10'b1100010000};
    vecs[6]  = '{1'b0, 1'b0, 1'b0, 1'b1, 4'b0101, 10'b1010010101};
    vecs[7]  = '{1'b0, 1'b0, 1'b1, 1'b0, 4'b0101, 10'b0000000101};
    vecs[8]  = '{1'b0, 1'b1, 1'b0, 1'b0, 4'b0101, 10'b1010110101};
    vecs[9]  = '{1'b0, 1'b0, 1'b1, 1'b0, 4'b0101, 10'b0000000101};
    vecs[10] = '{1'b1, 1'b0, 1'b1, 1'b0, 4'b0101, 10'b0000000101};
    vecs[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 4'b0101, 10'b0000000101};

    $display("[TB] reset");
    tick(); tick(); tick();
    check_output("reset_state",
      {bus.bist_en, bus.bist_run, bus.bist_shift, bus.bist_load, bus.bist_sdi,
       busy, done, tmo, mask, addr}, 0);
    rst = 1'b0;
    tick();

    $display("[TB] vector table");
    cfg_repair_addr = 36'hA_5A5A_5A5A;
    for (int i = 0; i < 12; i++) begin
      apply_stimulus(vecs[i]);
      tick();
      check_output($sformatf("vec%0d", i), main_out(), vecs[i].expect_out);
    end
    apply_stimulus('{1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 10'b0});
    tick();

    $display("[TB] pass readout");
    run_test(4'b0000, 36'h0, -1, 1'b0, sn, hn, bn);
    check_output("pass_setup_cycles", sn, 4);
    check_output("pass_shift_cycles", hn, 36);
    check_output("pass_excl", bn, 0);
    check_output("pass_done", done, 1);
    check_output("pass_mask", mask, 0);
    check_output("pass_addr", addr, 0);

    $display("[TB] fail readout");
    run_test(4'b0101, 36'h8_0000_01FB, -1, 1'b0, sn, hn, bn);
    check_output("fail_mask", mask, 4'b0101);
    check_output("fail_addr", addr, 36'h8_0000_01FB);
    check_output("fail_done", done, 1);
    check_output("fail_excl", bn, 0);

    $display("[TB] repair load");
    cfg_repair_addr = 36'hA_5A5A_5A5A;
    cfg_load = 1'b1; tick(); cfg_load = 1'b0;
    check_output("load_done_cleared", done, 0);
    cap = '0; n = 0;
    while (bus.bist_shift && n < SL + 5) begin
      cap = {cap[SL-2:0], bus.bist_sdi};
      n++; tick();
    end
    check_output("load_shift_cycles", n, 36);
    check_output("load_sdi_stream", cap, 36'hA_5A5A_5A5A);
    check_output("load_pulse", {bus.bist_en, bus.bist_shift, bus.bist_load}, 3'b101);
    tick();
    check_output("load_after_pulse", {bus.bist_en, bus.bist_load, busy}, 3'b001);
    tick();
    check_output("load_sts_done", {busy, done}, 2'b01);

    $display("[TB] timeout");
    cfg_start = 1'b1; tick(); cfg_start = 1'b0;
    check_output("tmo_cleared_on_start", t_tmo, 0);
    guard = 0;
    while (!tbus.bist_run && guard < 20) begin guard++; tick(); end
    n = 0;
    while (tbus.bist_run && n < 100) begin n++; tick(); end
    check_output("tmo_run_cycles", n, 16);
    check_output("tmo_flags", {t_tmo, t_busy, t_done}, 3'b100);
    check_output("tmo_bist_idle", {tbus.bist_en, tbus.bist_shift, tbus.bist_load}, 0);
    cfg_abort = 1'b1; tick(); cfg_abort = 1'b0; tick();

    $display("[TB] abort in readout");
    exp_addr = 36'h8_0000_01FB;
    exp_addr = (exp_addr << 11) | 36'h7FF;
    run_test(4'b0011, {SL{1'b1}}, 10, 1'b0, sn, hn, bn);
    check_output("abort_bist_off",
      {bus.bist_en, bus.bist_run, bus.bist_shift, bus.bist_load, bus.bist_sdi, busy}, 0);
    check_output("abort_shifts_seen", hn, 11);
    check_output("abort_addr_kept", addr, exp_addr);
    check_output("abort_sticky", {done, tmo, mask}, 6'b000011);
    tick();

    $display("[TB] reset in readout");
    run_test(4'b0101, {SL{1'b1}}, 10, 1'b1, sn, hn, bn);
    check_output("reset_mid_all_zero",
      {bus.bist_en, bus.bist_run, bus.bist_shift, bus.bist_load, bus.bist_sdi,
       busy, done, tmo, mask, addr}, 0);
    tick();
    check_output("reset_mid_stays_idle", {bus.bist_en, bus.bist_load, busy}, 0);

    $display("== %0d vectors applied, %0d miscompares ==", checks, fails);
    $finish;
  end
endmodule

// File: doc/mbist_seq_ctrl.md
MBIST_SEQ_CTRL -- requirements
Module: mbist_seq_ctrl

Interface
REQ-001 Parameter BIST_NO_SRAM, default 4: number of SRAMs under test.
REQ-002 Parameter BIST_ADDR_WD, default 9: repair-address width per SRAM.
REQ-003 Parameter SHIFT_LEN, default BIST_NO_SRAM*BIST_ADDR_WD (36): serial chain length.
REQ-004 Parameter SETUP_CYC, default 4: cycles bist_en is held high before bist_run asserts.
REQ-005 Parameter TMO_WD, default 20: width of the run-timeout counter.
REQ-006 wb_clk_i  in  1  sole clock; all logic on rising edge.
REQ-007 wb_rst_i  in  1  reset, synchronous, active-high.
REQ-008 cfg_start  in  1  one-cycle pulse; starts a test-and-readout sequence.
REQ-009 cfg_load  in  1  one-cycle pulse; starts a repair-address load sequence.
REQ-010 cfg_abort  in  1  level; forces return to IDLE.
REQ-011 cfg_repair_addr  in  SHIFT_LEN  repair addresses to load, shifted out MSB first.
REQ-012 bist_done  in  1  test-complete level from the MBIST engine.
REQ-013 bist_error  in  BIST_NO_SRAM  per-SRAM uncorrectable-error flags.
REQ-014 bist_sdo  in  1  serial chain output.
REQ-015 bist_en, bist_run, bist_shift, bist_load, bist_sdi  out  1 each  registered MBIST controls.
REQ-016 sts_busy  out  1  high in any state other than IDLE.
REQ-017 sts_done  out  1  sticky; set on sequence completion, cleared by the next cfg_start or cfg_load.
REQ-018 sts_timeout  out  1  sticky; set on run timeout, cleared by the next cfg_start.
REQ-019 sts_err_mask  out  BIST_NO_SRAM  bist_error captured at bist_done.
REQ-020 sts_err_addr  out  SHIFT_LEN  error-address chain captured during readout.

Function
REQ-021 FSM states: IDLE, SETUP, RUN, RDSHIFT, LDSHIFT, LDPULSE, DONE.
REQ-022 IDLE: all bist_* outputs 0; cfg_start -> SETUP; cfg_load -> LDSHIFT; if both pulse in the same cycle, cfg_start wins and cfg_load is dropped.
REQ-023 cfg_start/cfg_load outside IDLE are ignored.
REQ-024 SETUP: bist_en=1 for exactly SETUP_CYC cycles, then -> RUN.
REQ-025 RUN: bist_en=1, bist_run=1; timeout counter increments each cycle from 0.
REQ-026 RUN with bist_done=1: capture bist_error into sts_err_mask, deassert bist_run next cycle, -> RDSHIFT.
REQ-027 RUN with counter at all-ones and bist_done=0: set sts_timeout, drop all bist_* next cycle, -> IDLE; sts_done stays 0.
REQ-028 RDSHIFT: bist_en=1, bist_shift=1 for exactly SHIFT_LEN cycles; bist_sdi=0.
REQ-029 RDSHIFT: each cycle with bist_shift=1, sts_err_addr <= {sts_err_addr[SHIFT_LEN-2:0], bist_sdo}; the first bit shifted in ends at the MSB.
REQ-030 LDSHIFT: bist_en=1, bist_shift=1 for SHIFT_LEN cycles; cycle k (0-based) drives bist_sdi = cfg_repair_addr[SHIFT_LEN-1-k]; cfg_repair_addr is sampled into an internal register on entry.
REQ-031 LDPULSE: bist_en=1, bist_load=1 for exactly one cycle, bist_shift=0, -> DONE.
REQ-032 DONE: one cycle, bist_en=0, set sts_done, -> IDLE.
REQ-033 Shift counter is ceil(log2(SHIFT_LEN+1)) bits, reset to 0 on each shift-state entry, with no wrap inside a sequence.
REQ-034 bist_run, bist_shift and bist_load are mutually exclusive in every cycle.
REQ-035 cfg_abort=1 in any state: -> IDLE next cycle with all bist_* 0; sts_done and sts_timeout unchanged; partially shifted sts_err_addr is retained as-is.
REQ-036 cfg_abort has priority over cfg_start, bist_done and timeout in the same cycle.

Reset
REQ-037 wb_rst_i=1 at a rising edge: state=IDLE; all bist_* outputs, sts_*, counters and internal registers = 0, regardless of the current state.
REQ-038 Reset mid-sequence drops bist_en in the same edge; no partial bist_load pulse is issued.

Verification
REQ-039 Pass: cfg_start; bist_done after 100 RUN cycles with bist_error=4'b0000; bist_sdo=0 -> bist_en high for 4 SETUP cycles, 36 bist_shift cycles, sts_err_mask=0, sts_err_addr=0, sts_done=1.
REQ-040 Fail readout: bist_error=4'b0101; bist_sdo stream = 36'h8_0000_01FB MSB first -> sts_err_mask=4'b0101, sts_err_addr=36'h8_0000_01FB.
REQ-041 Load: cfg_repair_addr=36'hA_5A5A_5A5A, cfg_load -> bist_sdi carries the bits MSB first over 36 shift cycles; 1-cycle bist_load follows the last shift; sts_done=1.
REQ-042 Timeout: TMO_WD=4, bist_done held 0 -> sts_timeout=1 after 16 RUN cycles, FSM in IDLE, sts_done=0.
REQ-043 Abort/reset: cfg_abort at RDSHIFT shift 10 -> bist_* all 0 next cycle and sts_busy=0; repeat with wb_rst_i instead -> all outputs 0.
REQ-044 Collision: cfg_start and cfg_load in the same cycle -> SETUP entered, no LDSHIFT; cfg_start during RUN ignored.
